multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the 32-bit RISC datapath. It replaces the single-cycle opcode decoder with a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and write-back. It drives the shared unified memory through a req/ready handshake, so instructions take 3–5 cycles plus memory wait states. It sits between the instruction register (IR), the register file/ALU/PC multiplexers and the memory port.

## Interface
- No parameters; the opcode set is fixed: R-type 000000, j 000010, beq 000100, addi 001000, andi 001100, lw 100011, sw 101011.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; must be stable from DECODE until the instruction completes
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write request; valid with mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if the ALU zero flag is set
- pc_source  out  2  PC mux select: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump address
- alusrc_a  out  1  ALU A select: 0 = PC, 1 = rs
- alusrc_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- aluop  out  2  00 = add, 01 = sub, 10 = decode funct, 11 = and
- reg_dest  out  1  write-register select: 1 = rd, 0 = rt
- mem_to_reg  out  1  write-back data select: 1 = MDR, 0 = ALUOut
- reg_write  out  1  register-file write enable
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse on an undefined opcode
- state  out  4  current state code, for debug

## Operation
State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, IMMEXEC=9, IMMWB=10, JUMP=11, TRAP=12. Codes 13–15 go to FETCH with all outputs at default.

Any output not listed for a state is 0.

- **FETCH:** mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, aluop=00, pc_source=00.
  - If mem_ready: ir_write=1, pc_write=1 (Mealy, gated by mem_ready), next state DECODE.
  - Otherwise: hold in FETCH.
- **DECODE:** alusrc_a=0, alusrc_b=11, aluop=00 (computes the branch target into ALUOut). Dispatch on opcode:
  - lw or sw → MEMADR
  - R-type → RTEXEC
  - beq → BRANCH
  - addi or andi → IMMEXEC
  - j → JUMP
  - anything else → TRAP
- **MEMADR:** alusrc_a=1, alusrc_b=10, aluop=00. Next: lw → MEMRD, sw → MEMWR.
- **MEMRD:** mem_req=1, iord=1. On mem_ready → MEMWB.
- **MEMWB:** reg_write=1, mem_to_reg=1, reg_dest=0, instr_done=1. Next: FETCH.
- **MEMWR:** mem_req=1, mem_we=1, iord=1.
  - On mem_ready: instr_done=1 (Mealy), next FETCH.
- **RTEXEC:** alusrc_a=1, alusrc_b=00, aluop=10. Next: RTWB.
- **RTWB:** reg_write=1, reg_dest=1, mem_to_reg=0, instr_done=1. Next: FETCH.
- **BRANCH:** alusrc_a=1, alusrc_b=00, aluop=01, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
- **IMMEXEC:** alusrc_a=1, alusrc_b=10, aluop = 00 for addi, 11 for andi. Next: IMMWB.
- **IMMWB:** reg_write=1, reg_dest=0, mem_to_reg=0, instr_done=1. Next: FETCH.
- **JUMP:** pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
- **TRAP:** illegal=1. Next: FETCH. PC is already incremented, so execution continues at the next word. instr_done stays 0.

Handshake rules:
- mem_req, mem_we and iord are held stable from assertion until the cycle in which mem_ready=1.
- mem_ready sampled while mem_req=0 is ignored.

## Timing
- Reset:
  - While rst_n=0: state=FETCH and every output is forced to 0, including mem_req.
  - The first cycle after rst_n rises shows the FETCH outputs, with mem_req=1.
- Reset asserted mid-instruction, including during a memory wait: abandon immediately with no register or PC write. The memory side must tolerate the dropped request.
- State advances only on the rising clk edge. Outputs are combinational from state, plus mem_ready for the gated Mealy terms.
- Latency with zero memory wait:
  - lw: 5 cycles
  - sw, R-type, addi, andi: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 3 cycles (FETCH, DECODE, TRAP)
- Each cycle with mem_ready=0 during FETCH, MEMRD or MEMWR adds one cycle.
- instr_done and illegal are never asserted in the same cycle.
- opcode is ignored in FETCH; it is first sampled in DECODE.

## Test plan
- Reset, then lw (100011) with mem_ready always 1: state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 in cycle 5. One instr_done pulse.
- FETCH with mem_ready low for 2 cycles: mem_req=1 and iord=0 held for 3 cycles. ir_write and pc_write assert only in the 3rd. DECODE follows.
- R-type (000000): aluop=10 in RTEXEC. reg_write=1 and reg_dest=1 in RTWB. 4 cycles total.
- beq (000100) then andi (001100):
  - beq: BRANCH with aluop=01, pc_write_cond=1, pc_source=01.
  - andi: IMMEXEC with aluop=11, alusrc_b=10; then IMMWB.
- Undefined opcode 111111: FETCH, DECODE, TRAP with illegal=1 for one cycle. No reg_write and no instr_done. Next state FETCH.
- sw (101011) with 3 wait cycles in MEMWR: mem_we=1 and iord=1 held 4 cycles. Then drop rst_n during the next MEMRD wait: all outputs 0 immediately, state=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Memory-port handshake between the multi-cycle sequencer and the unified memory.
// mem_req/mem_we/iord are held by the master until the cycle the slave raises mem_ready.
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Moore-style multi-cycle sequencer: fetch, decode, execute, memory, write-back,
// with mem_ready-gated Mealy terms in FETCH and MEMWR.
module multicycle_control (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [5:0]                  opcode,
    multicycle_control_if.master        mem,
    output logic                        ir_write,
    output logic                        pc_write,
    output logic                        pc_write_cond,
    output logic [1:0]                  pc_source,
    output logic                        alusrc_a,
    output logic [1:0]                  alusrc_b,
    output logic [1:0]                  aluop,
    output logic                        reg_dest,
    output logic                        mem_to_reg,
    output logic                        reg_write,
    output logic                        instr_done,
    output logic                        illegal,
    output logic [3:0]                  state
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXEC  = 4'd6,
        S_RTWB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    // Outputs stay at their zero defaults while rst_n is low, so an abandoned
    // instruction never writes a register or the PC and the memory request drops.
    always_comb begin
        state_d       = S_FETCH;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.iord      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alusrc_a      = 1'b0;
        alusrc_b      = 2'b00;
        aluop         = 2'b00;
        reg_dest      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem.mem_req = 1'b1;
                    alusrc_b    = 2'b01;
                    if (mem.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else begin
                        state_d  = S_FETCH;
                    end
                end
                S_DECODE: begin
                    alusrc_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW:     state_d = S_MEMADR;
                        OP_RTYPE:         state_d = S_RTEXEC;
                        OP_BEQ:           state_d = S_BRANCH;
                        OP_ADDI, OP_ANDI: state_d = S_IMMEXEC;
                        OP_J:             state_d = S_JUMP;
                        default:          state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alusrc_a = 1'b1;
                    alusrc_b = 2'b10;
                    state_d  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem.mem_req = 1'b1;
                    mem.iord    = 1'b1;
                    state_d     = mem.mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem.mem_req = 1'b1;
                    mem.mem_we  = 1'b1;
                    mem.iord    = 1'b1;
                    instr_done  = mem.mem_ready;
                    state_d     = mem.mem_ready ? S_FETCH : S_MEMWR;
                end
                S_RTEXEC: begin
                    alusrc_a = 1'b1;
                    aluop    = 2'b10;
                    state_d  = S_RTWB;
                end
                S_RTWB: begin
                    reg_write  = 1'b1;
                    reg_dest   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alusrc_a      = 1'b1;
                    aluop         = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_IMMEXEC: begin
                    alusrc_a = 1'b1;
                    alusrc_b = 2'b10;
                    aluop    = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
                    state_d  = S_IMMWB;
                end
                S_IMMWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-instruction model expands each
// opcode and its memory wait counts into the expected cycle-by-cycle state and controls.
module tb_multicycle_control;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic [1:0] aluop;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] op;
        logic       rdy;
    } rec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] opcode;
    logic       ir_write, pc_write, pc_write_cond, alusrc_a, reg_dest;
    logic       mem_to_reg, reg_write, instr_done, illegal;
    logic [1:0] pc_source, alusrc_b, aluop;
    logic [3:0] state;
    ctrl_t      act;

    multicycle_control_if mem_if ();

    multicycle_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem           (mem_if.master),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alusrc_a      (alusrc_a),
        .alusrc_b      (alusrc_b),
        .aluop         (aluop),
        .reg_dest      (reg_dest),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .instr_done    (instr_done),
        .illegal       (illegal),
        .state         (state)
    );

    assign act = {mem_if.mem_req, mem_if.mem_we, mem_if.iord, ir_write, pc_write,
                  pc_write_cond, pc_source, alusrc_a, alusrc_b, aluop, reg_dest,
                  mem_to_reg, reg_write, instr_done, illegal};

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int ill_cnt = 0;
    rec_t exp_q[$];

    // Control word the datapath should see in a given phase of an instruction.
    function automatic ctrl_t ctrl_for(input logic [3:0] st, input logic [5:0] op, input logic rdy);
        ctrl_t c;
        c = '0;
        case (st)
            4'd0:  begin c.mem_req = 1; c.alusrc_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            4'd1:  c.alusrc_b = 2'b11;
            4'd2:  begin c.alusrc_a = 1; c.alusrc_b = 2'b10; end
            4'd3:  begin c.mem_req = 1; c.iord = 1; end
            4'd4:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
            4'd5:  begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; c.instr_done = rdy; end
            4'd6:  begin c.alusrc_a = 1; c.aluop = 2'b10; end
            4'd7:  begin c.reg_write = 1; c.reg_dest = 1; c.instr_done = 1; end
            4'd8:  begin c.alusrc_a = 1; c.aluop = 2'b01; c.pc_write_cond = 1;
                         c.pc_source = 2'b01; c.instr_done = 1; end
            4'd9:  begin c.alusrc_a = 1; c.alusrc_b = 2'b10;
                         c.aluop = (op == OP_ANDI) ? 2'b11 : 2'b00; end
            4'd10: begin c.reg_write = 1; c.instr_done = 1; end
            4'd11: begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
            4'd12: c.illegal = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic void push(input int st, input logic [5:0] op, input logic rdy);
        rec_t r;
        r.st = 4'(st);
        r.op = op;
        r.rdy = rdy;
        exp_q.push_back(r);
    endfunction

    // Expand one instruction: fw wait cycles in fetch, mw wait cycles in its memory phase.
    // The opcode pin carries junk during fetch, which the sequencer must ignore.
    function automatic void model_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(0, 6'($urandom), 1'b0);
        push(0, 6'($urandom), 1'b1);
        push(1, op, 1'($urandom_range(0, 1)));
        case (op)
            OP_LW: begin
                push(2, op, 1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) push(3, op, 1'b0);
                push(3, op, 1'b1);
                push(4, op, 1'($urandom_range(0, 1)));
            end
            OP_SW: begin
                push(2, op, 1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) push(5, op, 1'b0);
                push(5, op, 1'b1);
            end
            OP_RTYPE: begin push(6, op, 1'($urandom_range(0, 1))); push(7, op, 1'($urandom_range(0, 1))); end
            OP_BEQ:   push(8, op, 1'($urandom_range(0, 1)));
            OP_ADDI, OP_ANDI: begin
                push(9, op, 1'($urandom_range(0, 1)));
                push(10, op, 1'($urandom_range(0, 1)));
            end
            OP_J:     push(11, op, 1'($urandom_range(0, 1)));
            default:  push(12, op, 1'($urandom_range(0, 1)));
        endcase
    endfunction

    // driver: apply each expected cycle's inputs and compare the DUT against it
    task automatic drain(input string name);
        rec_t  r;
        ctrl_t e;
        int    cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            @(negedge clk);
            opcode = r.op;
            mem_if.mem_ready = r.rdy;
            #1;
            e = ctrl_for(r.st, r.op, r.rdy);
            n_cmp++;
            if (state !== r.st) begin
                n_fail++;
                $display("FAIL %s state cyc%0d: got %0d want %0d", name, cyc, state, r.st);
            end
            n_cmp++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s ctrl cyc%0d st%0d: got %h want %h", name, cyc, r.st, act, e);
            end
            if (instr_done === 1'b1) done_cnt++;
            if (illegal === 1'b1) ill_cnt++;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_if.mem_ready = 1'b1;
        opcode = OP_LW;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL reset state: got %0d want 0", state); end
        n_cmp++;
        if (act !== ctrl_t'('0)) begin n_fail++; $display("FAIL reset outputs: got %h want 0", act); end
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_lw();
        int d0;
        d0 = done_cnt;
        model_instr(OP_LW, 0, 0);
        drain("lw");
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL lw done pulses: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_fetch_wait();
        model_instr(OP_ADDI, 2, 0);
        drain("fetch_wait");
    endtask

    task automatic test_rtype();
        model_instr(OP_RTYPE, 0, 0);
        drain("rtype");
    endtask

    task automatic test_beq_andi();
        model_instr(OP_BEQ, 0, 0);
        model_instr(OP_ANDI, 0, 0);
        drain("beq_andi");
    endtask

    task automatic test_illegal();
        int d0, i0;
        d0 = done_cnt;
        i0 = ill_cnt;
        model_instr(6'b111111, 0, 0);
        model_instr(OP_J, 0, 0);
        drain("illegal");
        n_cmp++;
        if (ill_cnt - i0 !== 1) begin n_fail++; $display("FAIL illegal pulses: got %0d want 1", ill_cnt - i0); end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL illegal done pulses: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_sw_wait_reset();
        model_instr(OP_SW, 0, 3);
        push(0, 6'($urandom), 1'b1);
        push(1, OP_LW, 1'b1);
        push(2, OP_LW, 1'b1);
        push(3, OP_LW, 1'b0);
        push(3, OP_LW, 1'b0);
        drain("sw_wait");
        @(negedge clk);
        mem_if.mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL midreset state: got %0d want 0", state); end
        n_cmp++;
        if (act !== ctrl_t'('0)) begin n_fail++; $display("FAIL midreset outputs: got %h want 0", act); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_instr(OP_LW, 1, 1);
        drain("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[8];
        logic [5:0] op;
        int legal, bad, d0, i0;
        ops = '{OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW, 6'b000000};
        legal = 0; bad = 0;
        d0 = done_cnt; i0 = ill_cnt;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 7) begin
                op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 6)];
            end
            if (op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW}) legal++;
            else bad++;
            model_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        drain("b2b");
        n_cmp++;
        if (done_cnt - d0 !== legal) begin n_fail++; $display("FAIL b2b retired: got %0d want %0d", done_cnt - d0, legal); end
        n_cmp++;
        if (ill_cnt - i0 !== bad) begin n_fail++; $display("FAIL b2b traps: got %0d want %0d", ill_cnt - i0, bad); end
    endtask

    initial begin
        mem_if.mem_ready = 1'b0;
        opcode = 6'd0;
        test_reset();
        test_lw();
        test_fetch_wait();
        test_rtype();
        test_beq_andi();
        test_illegal();
        test_sw_wait_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
